// File: rtl/conv_loop_sequencer.sv
// Loop-nest controller for the single-MAC convolution datapath: walks y/x/outch and the
// inner inch/ky/kx reduction, issuing one tap per unstalled cycle into a 4-stage pipeline.
// state  | meaning
// IDLE   | waiting for start
// ISSUE  | one tap per non-stalled cycle
// DRAIN  | waiting for in-flight taps to leave the pipeline
// DONE   | one-cycle done pulse
module conv_loop_sequencer #(
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int INPUT_NB_CHANNELS  = 64,
    parameter int OUTPUT_NB_CHANNELS = 64,
    parameter int KERNEL_SIZE        = 3,
    localparam int XW = (FEATURE_MAP_WIDTH  > 1) ? $clog2(FEATURE_MAP_WIDTH)  : 1,
    localparam int YW = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1,
    localparam int IW = (INPUT_NB_CHANNELS  > 1) ? $clog2(INPUT_NB_CHANNELS)  : 1,
    localparam int CW = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1,
    localparam int KW = (KERNEL_SIZE        > 1) ? $clog2(KERNEL_SIZE)        : 1
) (
    input  logic          clk,
    input  logic          rst_in,
    input  logic          start,
    input  logic          stall,
    output logic          running,
    output logic          done,
    output logic          int_mem_re,
    output logic [XW-1:0] x_out,
    output logic [YW-1:0] y_out,
    output logic [CW-1:0] outch_out,
    output logic [IW-1:0] inch_out,
    output logic [KW-1:0] ky_out,
    output logic [KW-1:0] kx_out,
    output logic          write_ab,
    output logic          mac_valid,
    output logic          mac_accumulate_internal,
    output logic          mac_accumulate_with_0,
    output logic          output_valid,
    output logic [XW-1:0] output_x,
    output logic [YW-1:0] output_y,
    output logic [CW-1:0] output_ch
);
    localparam int TW = XW + YW + CW;
    localparam logic [XW-1:0] X_MAX = XW'(FEATURE_MAP_WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(FEATURE_MAP_HEIGHT - 1);
    localparam logic [IW-1:0] I_MAX = IW'(INPUT_NB_CHANNELS - 1);
    localparam logic [CW-1:0] C_MAX = CW'(OUTPUT_NB_CHANNELS - 1);
    localparam logic [KW-1:0] K_MAX = KW'(KERNEL_SIZE - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
    state_t state_q, state_d;

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [CW-1:0] oc_q, oc_d;
    logic [IW-1:0] ic_q, ic_d;
    logic [KW-1:0] ky_q, ky_d;
    logic [KW-1:0] kx_q, kx_d;

    logic          v1_q, v2_q, v3_q;
    logic          first1_q, first2_q;
    logic          last1_q, last2_q, last3_q;
    logic [TW-1:0] tag1_q, tag2_q, tag3_q;

    logic issue, first_tap, last_sum, last_layer;
    logic c_ky, c_ic, c_oc, c_x, c_y;

    assign issue      = (state_q == S_ISSUE) && !stall;
    assign first_tap  = (ic_q == '0) && (ky_q == '0) && (kx_q == '0);
    assign c_ky       = (kx_q == K_MAX);
    assign c_ic       = c_ky && (ky_q == K_MAX);
    assign c_oc       = c_ic && (ic_q == I_MAX);
    assign c_x        = c_oc && (oc_q == C_MAX);
    assign c_y        = c_x && (x_q == X_MAX);
    assign last_sum   = c_oc;
    assign last_layer = c_y && (y_q == Y_MAX);

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Stall freezes issue and drain; start is still accepted in IDLE and DONE always retires.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ISSUE;
            S_ISSUE: if (issue && last_layer) state_d = S_DRAIN;
            S_DRAIN: if (!stall && !v1_q && !v2_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        running                 = (state_q == S_ISSUE) || (state_q == S_DRAIN);
        done                    = (state_q == S_DONE);
        int_mem_re              = issue;
        write_ab                = v1_q && !stall;
        mac_valid               = v2_q && !stall;
        mac_accumulate_with_0   = v2_q && !stall && first2_q;
        mac_accumulate_internal = v2_q && !stall && !first2_q;
        output_valid            = v3_q && !stall && last3_q;
        {output_x, output_y, output_ch} = tag3_q;
        x_out     = x_q;
        y_out     = y_q;
        outch_out = oc_q;
        inch_out  = ic_q;
        ky_out    = ky_q;
        kx_out    = kx_q;
    end

    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        oc_d = oc_q;
        ic_d = ic_q;
        ky_d = ky_q;
        kx_d = kx_q;
        if (state_q == S_IDLE && start) begin
            x_d  = '0;
            y_d  = '0;
            oc_d = '0;
            ic_d = '0;
            ky_d = '0;
            kx_d = '0;
        end else if (issue) begin
            kx_d = c_ky ? '0 : kx_q + KW'(1);
            if (c_ky) ky_d = (ky_q == K_MAX) ? '0 : ky_q + KW'(1);
            if (c_ic) ic_d = (ic_q == I_MAX) ? '0 : ic_q + IW'(1);
            if (c_oc) oc_d = (oc_q == C_MAX) ? '0 : oc_q + CW'(1);
            if (c_x)  x_d  = (x_q == X_MAX) ? '0 : x_q + XW'(1);
            if (c_y)  y_d  = (y_q == Y_MAX) ? '0 : y_q + YW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            x_q      <= '0;
            y_q      <= '0;
            oc_q     <= '0;
            ic_q     <= '0;
            ky_q     <= '0;
            kx_q     <= '0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            first1_q <= 1'b0;
            first2_q <= 1'b0;
            last1_q  <= 1'b0;
            last2_q  <= 1'b0;
            last3_q  <= 1'b0;
            tag1_q   <= '0;
            tag2_q   <= '0;
            tag3_q   <= '0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            oc_q <= oc_d;
            ic_q <= ic_d;
            ky_q <= ky_d;
            kx_q <= kx_d;
            if (!stall) begin
                v1_q     <= issue;
                first1_q <= first_tap;
                last1_q  <= last_sum;
                tag1_q   <= {x_q, y_q, oc_q};
                v2_q     <= v1_q;
                first2_q <= first1_q;
                last2_q  <= last1_q;
                tag2_q   <= tag1_q;
                v3_q     <= v2_q;
                last3_q  <= last2_q;
                tag3_q   <= tag2_q;
            end
        end
    end
endmodule

// File: tb/tb_conv_loop_sequencer.sv
// Scoreboard bench for conv_loop_sequencer: a nested-loop reference model queues expected
// taps, MAC flags and output tags; negedge monitors pop and compare as the DUT emits them.
module tb_conv_loop_sequencer;
    localparam int AW = 4, AH = 4, AIC = 2, AOC = 2, AK = 3;
    localparam int AXW = (AW > 1) ? $clog2(AW) : 1;
    localparam int AYW = (AH > 1) ? $clog2(AH) : 1;
    localparam int AIW = (AIC > 1) ? $clog2(AIC) : 1;
    localparam int ACW = (AOC > 1) ? $clog2(AOC) : 1;
    localparam int AKW = (AK > 1) ? $clog2(AK) : 1;
    localparam int A_TAPS = AW * AH * AOC * AIC * AK * AK;
    localparam int A_SUM  = AIC * AK * AK;

    logic clk;
    int   cyc = 0;
    int   n_chk = 0, n_fail = 0;

    logic a_rst, a_start, a_stall;
    logic a_running, a_done, a_re, a_wab, a_mv, a_int, a_w0, a_ov;
    logic [AXW-1:0] a_x, a_ox;
    logic [AYW-1:0] a_y, a_oy;
    logic [ACW-1:0] a_oc, a_och;
    logic [AIW-1:0] a_ic;
    logic [AKW-1:0] a_ky, a_kx;

    logic b_rst, b_start, b_stall;
    logic b_running, b_done, b_re, b_wab, b_mv, b_int, b_w0, b_ov;
    logic [0:0] b_x, b_y, b_oc, b_ic, b_ky, b_kx, b_ox, b_oy, b_och;

    conv_loop_sequencer #(.FEATURE_MAP_WIDTH(AW), .FEATURE_MAP_HEIGHT(AH),
        .INPUT_NB_CHANNELS(AIC), .OUTPUT_NB_CHANNELS(AOC), .KERNEL_SIZE(AK)) dut_a (
        .clk(clk), .rst_in(a_rst), .start(a_start), .stall(a_stall),
        .running(a_running), .done(a_done), .int_mem_re(a_re),
        .x_out(a_x), .y_out(a_y), .outch_out(a_oc), .inch_out(a_ic),
        .ky_out(a_ky), .kx_out(a_kx), .write_ab(a_wab), .mac_valid(a_mv),
        .mac_accumulate_internal(a_int), .mac_accumulate_with_0(a_w0),
        .output_valid(a_ov), .output_x(a_ox), .output_y(a_oy), .output_ch(a_och));

    conv_loop_sequencer #(.FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2),
        .INPUT_NB_CHANNELS(1), .OUTPUT_NB_CHANNELS(1), .KERNEL_SIZE(1)) dut_b (
        .clk(clk), .rst_in(b_rst), .start(b_start), .stall(b_stall),
        .running(b_running), .done(b_done), .int_mem_re(b_re),
        .x_out(b_x), .y_out(b_y), .outch_out(b_oc), .inch_out(b_ic),
        .ky_out(b_ky), .kx_out(b_kx), .write_ab(b_wab), .mac_valid(b_mv),
        .mac_accumulate_internal(b_int), .mac_accumulate_with_0(b_w0),
        .output_valid(b_ov), .output_x(b_ox), .output_y(b_oy), .output_ch(b_och));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int pk(input int x, input int y, input int oc, input int ic,
                              input int ky, input int kx);
        return (x << 20) | (y << 16) | (oc << 12) | (ic << 8) | (ky << 4) | kx;
    endfunction

    // Reference model: queues for DUT A
    int tap_q[$];
    bit first_q[$];
    int out_q[$];
    int re_cnt, out_cnt, done_cnt, start_cyc, last_re_cyc, last_out_cyc;
    bit timing_en = 1'b0;

    task automatic build_a();
        tap_q.delete();
        first_q.delete();
        out_q.delete();
        for (int y = 0; y < AH; y++)
            for (int x = 0; x < AW; x++)
                for (int oc = 0; oc < AOC; oc++) begin
                    for (int t = 0; t < A_SUM; t++) begin
                        tap_q.push_back(pk(x, y, oc, t / (AK * AK), (t / AK) % AK, t % AK));
                        first_q.push_back(t == 0);
                    end
                    out_q.push_back(pk(x, y, oc, 0, 0, 0));
                end
        re_cnt = 0;
        out_cnt = 0;
        done_cnt = 0;
    endtask

    initial forever begin
        int got, exp_t;
        bit f;
        @(negedge clk);
        if (a_stall) chk("stall_strobes", {a_re, a_wab, a_mv, a_ov}, 0);
        if (a_re) begin
            chk("tap_expected", tap_q.size() > 0, 1);
            if (tap_q.size() > 0) begin
                exp_t = tap_q.pop_front();
                got = pk(int'(a_x), int'(a_y), int'(a_oc), int'(a_ic), int'(a_ky), int'(a_kx));
                chk("tap_order", got, exp_t);
            end
            re_cnt++;
            last_re_cyc = cyc;
        end
        if (a_mv) begin
            chk("mac_expected", first_q.size() > 0, 1);
            if (first_q.size() > 0) begin
                f = first_q.pop_front();
                chk("mac_with_0", a_w0, f);
                chk("mac_internal", a_int, !f);
            end
        end else begin
            chk("mac_idle", {a_w0, a_int}, 0);
        end
        if (a_ov) begin
            chk("out_expected", out_q.size() > 0, 1);
            if (out_q.size() > 0) begin
                exp_t = out_q.pop_front();
                chk("out_tag", pk(int'(a_ox), int'(a_oy), int'(a_och), 0, 0, 0), exp_t);
            end
            if (timing_en) begin
                if (out_cnt == 0) chk("first_out_latency", cyc - start_cyc, 21);
                else chk("out_spacing", cyc - last_out_cyc, A_SUM);
            end
            last_out_cyc = cyc;
            out_cnt++;
        end
        if (a_done) begin
            done_cnt++;
            if (timing_en) chk("done_after_last_re", cyc - last_re_cyc, 4);
        end
    end

    // DUT B: every tap is both first and last of its sum
    int b_out_q[$];
    int b_re_cnt = 0, b_mv_cnt = 0, b_out_cnt = 0, b_done_cnt = 0, b_last_out = 0;

    initial forever begin
        int exp_t;
        @(negedge clk);
        if (b_running) chk("b_internal_never", b_int, 0);
        if (b_re) b_re_cnt++;
        if (b_mv) begin
            b_mv_cnt++;
            chk("b_with_0", b_w0, 1);
        end
        if (b_ov) begin
            chk("b_out_expected", b_out_q.size() > 0, 1);
            if (b_out_q.size() > 0) begin
                exp_t = b_out_q.pop_front();
                chk("b_out_tag", pk(int'(b_ox), int'(b_oy), int'(b_och), 0, 0, 0), exp_t);
            end
            if (b_out_cnt > 0) chk("b_out_consecutive", cyc - b_last_out, 1);
            b_last_out = cyc;
            b_out_cnt++;
        end
        if (b_done) b_done_cnt++;
    end

    task automatic run_a(input int stall_pct, input int extra_start_at);
        int guard;
        build_a();
        timing_en = (stall_pct == 0);
        @(posedge clk); #1;
        a_start = 1'b1;
        a_stall = (stall_pct > 0);
        start_cyc = cyc;
        @(posedge clk); #1;
        a_start = 1'b0;
        chk("running_after_start", a_running, 1);
        if (stall_pct > 0) chk("issue_held_by_stall", a_re, 0);
        guard = 0;
        while (done_cnt == 0 && guard < 5000) begin
            a_stall = (stall_pct > 0) && ($urandom_range(99) < stall_pct);
            a_start = (extra_start_at > 0) && (re_cnt == extra_start_at);
            @(posedge clk); #1;
            guard++;
        end
        a_stall = 1'b0;
        a_start = 1'b0;
        chk("done_seen", done_cnt > 0, 1);
        repeat (10) @(posedge clk);
        #1;
        chk("done_once", done_cnt, 1);
        chk("re_count", re_cnt, A_TAPS);
        chk("out_count", out_cnt, AW * AH * AOC);
        chk("taps_left", tap_q.size(), 0);
        chk("outs_left", out_q.size(), 0);
        chk("running_after_done", a_running, 0);
    endtask

    task automatic run_reset_abort();
        int guard, saved_re;
        build_a();
        timing_en = 1'b0;
        @(posedge clk); #1;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        guard = 0;
        while (re_cnt < 100 && guard < 1000) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("reached_tap_100", re_cnt >= 100, 1);
        a_rst = 1'b1;
        @(posedge clk); #1;
        a_rst = 1'b0;
        chk("abort_outputs_zero", {a_running, a_done, a_re, a_x, a_y, a_oc, a_ic, a_ky, a_kx,
            a_wab, a_mv, a_int, a_w0, a_ov, a_ox, a_oy, a_och}, 0);
        saved_re = re_cnt;
        repeat (10) @(posedge clk);
        #1;
        chk("no_done_after_abort", done_cnt, 0);
        chk("no_issue_after_abort", re_cnt, saved_re);
        a_start = 1'b1;
        a_rst = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        a_rst = 1'b0;
        chk("start_with_reset_ignored", a_running, 0);
        @(posedge clk); #1;
        chk("still_idle", {a_running, a_re}, 0);
    endtask

    task automatic run_b();
        int guard;
        b_out_q.delete();
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 2; x++)
                b_out_q.push_back(pk(x, y, 0, 0, 0, 0));
        @(posedge clk); #1;
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        guard = 0;
        while (b_done_cnt == 0 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("b_done_seen", b_done_cnt, 1);
        chk("b_re_count", b_re_cnt, 4);
        chk("b_mac_count", b_mv_cnt, 4);
        chk("b_out_count", b_out_cnt, 4);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        a_rst = 1'b1; a_start = 1'b0; a_stall = 1'b0;
        b_rst = 1'b1; b_start = 1'b0; b_stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_zero", {a_running, a_done, a_re, a_x, a_y, a_oc, a_ic, a_ky, a_kx,
            a_wab, a_mv, a_int, a_w0, a_ov, a_ox, a_oy, a_och}, 0);
        a_rst = 1'b0;
        b_rst = 1'b0;
        run_a(0, 0);
        run_b();
        run_a(30, 0);
        run_reset_abort();
        run_a(0, 0);
        run_a(0, 200);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/conv_loop_sequencer.md
Name: conv_loop_sequencer

Overview:
- Loop-nest controller for the single-MAC convolution datapath.
- Walks output pixel (x, y) and output channel, and for each one the inner reduction over input channel and kernel taps (inch, ky, kx).
- Drives the on-chip memory read enable, a/b operand register writes, MAC control and output-valid/coordinate tags, with a start/running/done handshake and a stall input.
- Sits between the top-level glue and the memory/MAC datapath.

Parameters:
FEATURE_MAP_WIDTH, 1024, output pixels per row (x range)
FEATURE_MAP_HEIGHT, 1024, rows (y range)
INPUT_NB_CHANNELS, 64, reduction channels (inch range)
OUTPUT_NB_CHANNELS, 64, output channels (outch range)
KERNEL_SIZE, 3, kernel side (ky, kx range)

Ports:
clk  in  1  clock
rst_in  in  1  reset, synchronous, active-high
start  in  1  single-cycle pulse; begins a full layer when idle
stall  in  1  1 = freeze issue and pipeline this cycle
running  out  1  high from the cycle after accepted start until the cycle done pulses
done  out  1  one-cycle pulse after the last output is emitted
int_mem_re  out  1  read enable for input/kernel memories; counters are valid this cycle
x_out  out  $clog2(FEATURE_MAP_WIDTH)  current x (address stage)
y_out  out  $clog2(FEATURE_MAP_HEIGHT)  current y
outch_out  out  $clog2(OUTPUT_NB_CHANNELS)  current output channel
inch_out  out  $clog2(INPUT_NB_CHANNELS)  current input channel
ky_out  out  $clog2(KERNEL_SIZE)  current kernel row
kx_out  out  $clog2(KERNEL_SIZE)  current kernel column
write_ab  out  1  load a/b operand registers (memory data valid)
mac_valid  out  1  MAC consumes a, b this cycle
mac_accumulate_internal  out  1  accumulate onto internal MAC register
mac_accumulate_with_0  out  1  start a new sum (partial sum = 0)
output_valid  out  1  MAC output holds a finished result
output_x / output_y / output_ch  out  as x_out/y_out/outch_out  coordinates of the result on output_valid

Behaviour:
- Every counter width is max(1, $clog2(N)).
- Reset (synchronous, dominates start/stall): state IDLE; all outputs 0; all counters 0; pipeline valids cleared. Reset mid-layer aborts immediately, with no done pulse.
- States:
  - IDLE: start=1 -> ISSUE, counters 0.
  - ISSUE: one tap issued per non-stalled cycle. After the last tap of the last output it goes to DRAIN.
  - DRAIN: waits until all pipeline valids are empty, then goes to DONE.
  - DONE: pulses done for 1 cycle, then returns to IDLE.
  - start is ignored outside IDLE.
- Loop order, innermost first: kx, ky, inch, outch, x, y. Each counter wraps to 0 at its max-1 and carries to the next. The layer ends when all counters are at max-1.
- Pipeline, with stall=0 throughout:
  - Stage 0 (cycle t): int_mem_re=1 and counters valid.
  - Stage 1 (t+1): write_ab=1.
  - Stage 2 (t+2): mac_valid=1. mac_accumulate_with_0=1 iff the tap is the first of its sum (inch=ky=kx=0). mac_accumulate_internal is the complement while mac_valid=1, else 0.
  - Stage 3 (t+3): if the tap was the last of its sum (inch, ky, kx all max-1), output_valid=1 with that sum's x, y, outch.
- Stall=1: counters, state and all pipeline stage registers hold; int_mem_re, write_ab, mac_valid and output_valid are forced 0 that cycle. Re-asserted on the first cycle after stall drops, with no tap lost or duplicated.
- Throughput: exactly 1 tap/cycle without stall. Layer length is W*H*OC*IC*K*K taps. done occurs 4 cycles after the last issue cycle (3 pipeline + DONE).
- Boundary cases:
  - K=1 or IC=1: every tap is both first and last. Both with_0 and output_valid behave accordingly.
  - start together with stall in IDLE: accepted; issue waits for stall=0.
  - start in the same cycle as rst_in: ignored.

Test Plan:
1. W=H=4, IC=OC=2, K=3, start pulse, no stall:
   - 576 consecutive int_mem_re cycles.
   - 32 output_valid pulses, the first 21 cycles after start, then every 18 cycles.
   - done exactly once, 4 cycles after the last int_mem_re.
2. Same config, check counter order:
   - Cycle 0 issues (x,y,oc,ic,ky,kx)=(0,0,0,0,0,0); cycle 1 is kx=1; cycle 3 is ky=1,kx=0; cycle 9 is ic=1; cycle 18 is oc=1; cycle 36 is x=1.
   - output tags run (0,0,0),(0,0,1),(1,0,0)...
3. K=1, IC=1, W=H=2, OC=1:
   - mac_accumulate_with_0=1 on every mac_valid; mac_accumulate_internal never 1.
   - 4 output_valid pulses on consecutive cycles.
4. Random stall (30%) on config 1:
   - Same tap sequence and output tags as scenario 1, in the same order.
   - No control strobe is high during any stall cycle.
5. rst_in asserted at tap 100:
   - Next cycle all outputs 0 and running=0, with no done pulse.
   - A fresh start reproduces scenario 1 exactly.
6. start pulsed while running:
   - Ignored; the sequence is unchanged and done occurs once.
